// File: rtl/jellyvl_etherneco_packet_pkg.sv
// Definitions shared by the EtherNeco packet TX and RX sides: parser states,
// framing bytes and the CRC-32 polynomial.
package jellyvl_etherneco_packet_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    LENGTH,
    TYPE,
    NODE,
    PAYLOAD,
    FCS,
    DISCARD
  } state_t;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;

endpackage

// File: rtl/jellyvl_etherneco_packet_rx_if.sv
// Byte stream carrying EtherNeco frame bytes with first/last framing marks.
// Handshake: valid-only, no ready; a byte is taken on every clk edge where
// valid=1, and first/last/data are meaningful only in those cycles.
interface jellyvl_etherneco_packet_rx_if;
  logic       first;
  logic       last;
  logic [7:0] data;
  logic       valid;

  modport master (output first, last, data, valid);
  modport slave  (input  first, last, data, valid);
endinterface

// File: rtl/jelly2_calc_crc.sv
// Registered CRC engine: folds DATA_WIDTH bits per enabled cycle into the
// running CRC; in_update=0 restarts from all-ones (no final inversion).
module jelly2_calc_crc #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    CRC_WIDTH  = 32,
  parameter logic [CRC_WIDTH-1:0]  POLY       = 32'h04C11DB7,
  parameter bit                    REVERSED   = 1'b0
) (
  input  logic                  reset,
  input  logic                  clk,
  input  logic                  cke,
  input  logic                  in_update,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic [CRC_WIDTH-1:0]  out_crc
);

  logic [CRC_WIDTH-1:0] poly_rev;
  logic [CRC_WIDTH-1:0] crc_next;

  always_comb begin
    poly_rev = '0;
    for (int i = 0; i < CRC_WIDTH; i++) begin
      poly_rev[i] = POLY[CRC_WIDTH-1-i];
    end
  end

  // Non-reversed: data MSB first, shift left. Reversed: data LSB first, shift right.
  always_comb begin
    crc_next = in_update ? out_crc : '1;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (REVERSED) begin
        crc_next = (crc_next[0] ^ in_data[i]) ? ((crc_next >> 1) ^ poly_rev) : (crc_next >> 1);
      end else begin
        crc_next = (crc_next[CRC_WIDTH-1] ^ in_data[DATA_WIDTH-1-i]) ? ((crc_next << 1) ^ POLY) : (crc_next << 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_crc <= '1;
    end else if (cke && in_valid) begin
      out_crc <= crc_next;
    end
  end

endmodule

// File: rtl/jellyvl_etherneco_packet_rx.sv
// EtherNeco receive parser: strips preamble/SFD, captures the header, forwards
// the payload as a first/last stream and reports FCS/framing status at frame end.
module jellyvl_etherneco_packet_rx
  import jellyvl_etherneco_packet_pkg::*;
#(
  parameter int PREAMBLE_LEN = 7,
  parameter bit CHECK_TRAIL  = 1'b1
) (
  input  logic                           reset,
  input  logic                           clk,
  jellyvl_etherneco_packet_rx_if.slave   s,
  output logic                           rx_start,
  output logic [15:0]                    rx_length,
  output logic [7:0]                     rx_type,
  output logic [7:0]                     rx_node,
  jellyvl_etherneco_packet_rx_if.master  m,
  output logic                           rx_end,
  output logic                           rx_ok,
  output logic                           rx_error,
  output state_t                         state
);

  logic [15:0] cnt;
  logic [15:0] len_tmp;
  logic [7:0]  type_tmp;
  logic [23:0] fcs;
  logic [31:0] crc;
  logic        crc_update;
  logic        crc_valid;
  logic        fcs_good;
  logic        trail_good;

  assign crc_update = !(state == LENGTH && cnt == 16'd0);
  assign crc_valid  = !s.first && (state == LENGTH || state == TYPE || state == NODE || state == PAYLOAD);

  jelly2_calc_crc #(
    .DATA_WIDTH (8),
    .CRC_WIDTH  (32),
    .POLY       (CRC_POLY),
    .REVERSED   (1'b0)
  ) u_crc (
    .reset     (reset),
    .clk       (clk),
    .cke       (s.valid),
    .in_update (crc_update),
    .in_data   (s.data),
    .in_valid  (crc_valid),
    .out_crc   (crc)
  );

  // The 4th FCS byte completes the 32-bit word straight from the input.
  assign fcs_good   = ({s.data, fcs} == crc);
  assign trail_good = s.last || !CHECK_TRAIL;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      len_tmp   <= '0;
      type_tmp  <= '0;
      fcs       <= '0;
      rx_start  <= 1'b0;
      rx_length <= '0;
      rx_type   <= '0;
      rx_node   <= '0;
      rx_end    <= 1'b0;
      rx_ok     <= 1'b0;
      rx_error  <= 1'b0;
      m.first   <= 1'b0;
      m.last    <= 1'b0;
      m.data    <= '0;
      m.valid   <= 1'b0;
    end else begin
      rx_start <= 1'b0;
      rx_end   <= 1'b0;
      rx_ok    <= 1'b0;
      rx_error <= 1'b0;
      m.first  <= 1'b0;
      m.last   <= 1'b0;
      m.valid  <= 1'b0;
      if (s.valid) begin
        // A DISCARD frame already reported its error, so a restart there is silent.
        if (s.first && state != IDLE && state != DISCARD) begin
          rx_end   <= 1'b1;
          rx_error <= 1'b1;
        end
        if (state == IDLE || s.first) begin
          state <= IDLE;
          if (s.first && s.last) begin
            rx_end   <= 1'b1;
            rx_error <= 1'b1;
          end else if (s.first && s.data == PREAMBLE_BYTE) begin
            state <= PREAMBLE;
            cnt   <= 16'd1;
          end
        end else if (s.last && !(state == FCS && cnt == 16'd3)) begin
          state <= IDLE;
          if (state != DISCARD) begin
            rx_end   <= 1'b1;
            rx_error <= 1'b1;
          end
          if (state == PAYLOAD) begin
            m.valid <= 1'b1;
            m.first <= (cnt == rx_length);
            m.last  <= 1'b1;
            m.data  <= s.data;
          end
        end else begin
          case (state)
            PREAMBLE: begin
              if (cnt == 16'(PREAMBLE_LEN)) begin
                if (s.data == SFD_BYTE) begin
                  state <= LENGTH;
                  cnt   <= '0;
                end else begin
                  state    <= DISCARD;
                  rx_end   <= 1'b1;
                  rx_error <= 1'b1;
                end
              end else if (s.data == PREAMBLE_BYTE) begin
                cnt <= cnt + 16'd1;
              end else begin
                state    <= DISCARD;
                rx_end   <= 1'b1;
                rx_error <= 1'b1;
              end
            end
            LENGTH: begin
              if (cnt == 16'd0) begin
                len_tmp[7:0] <= s.data;
                cnt          <= 16'd1;
              end else begin
                len_tmp[15:8] <= s.data;
                state         <= TYPE;
              end
            end
            TYPE: begin
              type_tmp <= s.data;
              state    <= NODE;
            end
            NODE: begin
              rx_length <= len_tmp;
              rx_type   <= type_tmp;
              rx_node   <= s.data;
              rx_start  <= 1'b1;
              cnt       <= len_tmp;
              state     <= PAYLOAD;
            end
            PAYLOAD: begin
              m.valid <= 1'b1;
              m.first <= (cnt == rx_length);
              m.last  <= (cnt == 16'd0);
              m.data  <= s.data;
              if (cnt == 16'd0) begin
                state <= FCS;
              end else begin
                cnt <= cnt - 16'd1;
              end
            end
            FCS: begin
              if (cnt == 16'd3) begin
                rx_end   <= 1'b1;
                rx_ok    <= fcs_good && trail_good;
                rx_error <= !(fcs_good && trail_good);
                state    <= trail_good ? IDLE : DISCARD;
              end else begin
                fcs <= {s.data, fcs[23:8]};
                cnt <= cnt + 16'd1;
              end
            end
            DISCARD: ;
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_jellyvl_etherneco_packet_rx.sv
// Bench for the EtherNeco RX parser: frames are built from the wire format,
// expected events (header, payload bytes, frame status) carry the cycle they must appear in.
module tb_jellyvl_etherneco_packet_rx;
  import jellyvl_etherneco_packet_pkg::*;

  localparam int PRE = 7;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_start, rx_end, rx_ok, rx_error;
  logic [15:0] rx_length;
  logic [7:0]  rx_type, rx_node;
  state_t      state;

  jellyvl_etherneco_packet_rx_if s_if ();
  jellyvl_etherneco_packet_rx_if m_if ();

  jellyvl_etherneco_packet_rx #(
    .PREAMBLE_LEN (PRE),
    .CHECK_TRAIL  (1'b1)
  ) dut (
    .reset     (reset),
    .clk       (clk),
    .s         (s_if),
    .rx_start  (rx_start),
    .rx_length (rx_length),
    .rx_type   (rx_type),
    .rx_node   (rx_node),
    .m         (m_if),
    .rx_end    (rx_end),
    .rx_ok     (rx_ok),
    .rx_error  (rx_error),
    .state     (state)
  );

  // ---- clock / reset ----
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---- stimulus and scoreboard storage ----
  // event word: {tag[1:0], cycle[29:0], info[31:0]}; tag 1=start, 2=payload, 3=end
  logic [9:0]  stim_q[$];
  int          acc_q[$];
  logic [63:0] exp_q[$];
  logic [63:0] obs_q[$];
  logic [7:0]  pay_q[$];
  int          frame_base;
  int          vectors = 0;
  int          miscompares = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (rx_start) obs_q.push_back({2'd1, 30'(cyc), rx_length, rx_type, rx_node});
      if (m_if.valid) obs_q.push_back({2'd2, 30'(cyc), 22'd0, m_if.first, m_if.last, m_if.data});
      if (rx_end) obs_q.push_back({2'd3, 30'(cyc), 30'd0, rx_ok, rx_error});
    end
  end

  // ---- reference model ----
  function automatic logic [31:0] crc_model(input logic [7:0] b[$]);
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFFFFFF;
    foreach (b[k]) begin
      for (int j = 7; j >= 0; j--) begin
        fb = c[31] ^ b[k][j];
        c  = {c[30:0], 1'b0};
        if (fb) c = c ^ CRC_POLY;
      end
    end
    return c;
  endfunction

  task automatic add_frame(input logic [15:0] len, input logic [7:0] typ, input logic [7:0] node,
                           input bit counting, input logic [31:0] fcs_xor);
    logic [7:0]  body[$];
    logic [31:0] fcs;
    frame_base = stim_q.size();
    pay_q.delete();
    for (int i = 0; i < PRE; i++) stim_q.push_back({(i == 0), 1'b0, PREAMBLE_BYTE});
    stim_q.push_back({2'b00, SFD_BYTE});
    body = {len[7:0], len[15:8], typ, node};
    for (int i = 0; i <= int'(len); i++) begin
      pay_q.push_back(counting ? 8'(i + 1) : 8'($urandom));
      body.push_back(pay_q[i]);
    end
    fcs = crc_model(body) ^ fcs_xor;
    foreach (body[k]) stim_q.push_back({2'b00, body[k]});
    for (int k = 0; k < 4; k++) stim_q.push_back({1'b0, (k == 3), fcs[8*k +: 8]});
  endtask

  task automatic push_ev(input logic [1:0] tag, input int idx, input logic [31:0] info);
    exp_q.push_back({tag, 30'(idx), info});
  endtask

  task automatic expect_good_frame(input int base, input logic [15:0] len, input logic [7:0] typ,
                                   input logic [7:0] node, input bit ok);
    int hdr;
    hdr = base + PRE + 4;
    push_ev(2'd1, hdr, {len, typ, node});
    for (int i = 0; i <= int'(len); i++) push_ev(2'd2, hdr + 1 + i, {22'd0, (i == 0), (i == int'(len)), pay_q[i]});
    push_ev(2'd3, hdr + int'(len) + 5, {30'd0, ok, !ok});
  endtask

  // ---- driver ----
  task automatic drive_stream(input int n, input int gmin, input int gmax);
    int idx;
    acc_q.delete();
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(gmax, gmin)) begin
        @(negedge clk);
        s_if.valid = 1'b0;
        s_if.first = 1'($urandom);
        s_if.last  = 1'($urandom);
        s_if.data  = 8'($urandom);
      end
      @(negedge clk);
      {s_if.first, s_if.last, s_if.data} = stim_q[i];
      s_if.valid = 1'b1;
      acc_q.push_back(cyc + 1);
    end
    @(negedge clk);
    s_if.valid = 1'b0;
    s_if.first = 1'b0;
    s_if.last  = 1'b0;
    foreach (exp_q[k]) begin
      idx = int'(exp_q[k][61:32]);
      if (idx < acc_q.size()) exp_q[k][61:32] = 30'(acc_q[idx]);
    end
  endtask

  task automatic clear_all();
    stim_q.delete();
    exp_q.delete();
    obs_q.delete();
  endtask

  // ---- tests ----
  task automatic test_reset();
    reset = 1'b1;
    s_if.valid = 1'b1;
    s_if.first = 1'b1;
    s_if.last  = 1'b0;
    s_if.data  = PREAMBLE_BYTE;
    repeat (3) @(negedge clk);
    vectors++;
    if ({rx_start, rx_end, rx_ok, rx_error, m_if.first, m_if.last, m_if.valid, rx_length, rx_type, rx_node, m_if.data} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs got %b/%h/%h/%h/%h exp all zero", {rx_start, rx_end, rx_ok, rx_error, m_if.first, m_if.last, m_if.valid}, rx_length, rx_type, rx_node, m_if.data);
    end
    vectors++;
    if (state !== IDLE) begin miscompares++; $display("FAIL reset_state got %0d exp %0d", state, IDLE); end
    s_if.valid = 1'b0;
    s_if.first = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_loopback();
    clear_all();
    add_frame(16'd3, 8'h12, 8'h05, 1'b1, 32'h0);
    expect_good_frame(frame_base, 16'd3, 8'h12, 8'h05, 1'b1);
    drive_stream(stim_q.size(), 0, 0);
    repeat (4) @(negedge clk);
    vectors++;
    if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL loopback_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL loopback_ev%0d got %h exp %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_fcs_error();
    clear_all();
    add_frame(16'd3, 8'h12, 8'h05, 1'b1, 32'h0001_0000);
    expect_good_frame(frame_base, 16'd3, 8'h12, 8'h05, 1'b0);
    drive_stream(stim_q.size(), 0, 1);
    repeat (4) @(negedge clk);
    vectors++;
    if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL fcs_error_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL fcs_error_ev%0d got %h exp %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_abort();
    int hdr;
    clear_all();
    add_frame(16'd7, 8'h21, 8'h03, 1'b0, 32'h0);
    hdr = frame_base + PRE + 4;
    while (stim_q.size() > hdr + 4) void'(stim_q.pop_back());
    stim_q[hdr + 3] = {1'b0, 1'b1, 8'h00};
    push_ev(2'd1, hdr, {16'd7, 8'h21, 8'h03});
    push_ev(2'd2, hdr + 1, {22'd0, 1'b1, 1'b0, pay_q[0]});
    push_ev(2'd2, hdr + 2, {22'd0, 1'b0, 1'b0, pay_q[1]});
    push_ev(2'd2, hdr + 3, {22'd0, 1'b0, 1'b1, 8'h00});
    push_ev(2'd3, hdr + 3, {30'd0, 1'b0, 1'b1});
    drive_stream(stim_q.size(), 0, 2);
    repeat (4) @(negedge clk);
    vectors++;
    if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL abort_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL abort_ev%0d got %h exp %h", i, obs_q[i], exp_q[i]); end
    end
    vectors++;
    if (state !== IDLE) begin miscompares++; $display("FAIL abort_state got %0d exp %0d", state, IDLE); end
  endtask

  task automatic test_preamble_error();
    logic [15:0] len;
    clear_all();
    add_frame(16'd5, 8'h33, 8'h44, 1'b0, 32'h0);
    stim_q[frame_base + 1] = {2'b00, 8'h54};
    push_ev(2'd3, frame_base + 1, {30'd0, 1'b0, 1'b1});
    len = 16'($urandom_range(6, 0));
    add_frame(len, 8'h55, 8'h66, 1'b0, 32'h0);
    expect_good_frame(frame_base, len, 8'h55, 8'h66, 1'b1);
    drive_stream(stim_q.size(), 0, 1);
    repeat (4) @(negedge clk);
    vectors++;
    if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL preamble_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL preamble_ev%0d got %h exp %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_first_restart();
    int hdr;
    clear_all();
    add_frame(16'd9, 8'h0A, 8'h0B, 1'b0, 32'h0);
    hdr = frame_base + PRE + 4;
    while (stim_q.size() > hdr + 6) void'(stim_q.pop_back());
    push_ev(2'd1, hdr, {16'd9, 8'h0A, 8'h0B});
    for (int i = 0; i < 5; i++) push_ev(2'd2, hdr + 1 + i, {22'd0, (i == 0), 1'b0, pay_q[i]});
    add_frame(16'd2, 8'h0C, 8'h0D, 1'b0, 32'h0);
    push_ev(2'd3, frame_base, {30'd0, 1'b0, 1'b1});
    expect_good_frame(frame_base, 16'd2, 8'h0C, 8'h0D, 1'b1);
    drive_stream(stim_q.size(), 0, 1);
    repeat (4) @(negedge clk);
    vectors++;
    if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL first_restart_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL first_restart_ev%0d got %h exp %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_gapped();
    clear_all();
    add_frame(16'd0, 8'h7E, 8'h01, 1'b0, 32'h0);
    expect_good_frame(frame_base, 16'd0, 8'h7E, 8'h01, 1'b1);
    drive_stream(stim_q.size(), 2, 2);
    repeat (4) @(negedge clk);
    vectors++;
    if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL gapped_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL gapped_ev%0d got %h exp %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_trail_and_short();
    clear_all();
    add_frame(16'd1, 8'h90, 8'h91, 1'b0, 32'h0);
    stim_q[stim_q.size() - 1][8] = 1'b0;
    stim_q.push_back({2'b01, 8'hAA});
    expect_good_frame(frame_base, 16'd1, 8'h90, 8'h91, 1'b0);
    push_ev(2'd3, stim_q.size(), {30'd0, 1'b0, 1'b1});
    stim_q.push_back({2'b11, PREAMBLE_BYTE});
    drive_stream(stim_q.size(), 0, 1);
    repeat (4) @(negedge clk);
    vectors++;
    if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL trail_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL trail_ev%0d got %h exp %h", i, obs_q[i], exp_q[i]); end
    end
    vectors++;
    if (state !== IDLE) begin miscompares++; $display("FAIL trail_state got %0d exp %0d", state, IDLE); end
  endtask

  task automatic test_reset_mid_fcs();
    clear_all();
    add_frame(16'd4, 8'hC1, 8'hC2, 1'b0, 32'h0);
    expect_good_frame(frame_base, 16'd4, 8'hC1, 8'hC2, 1'b1);
    void'(exp_q.pop_back());
    drive_stream(frame_base + PRE + 4 + 4 + 4, 0, 0);
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if ({rx_start, rx_end, rx_ok, rx_error, m_if.first, m_if.last, m_if.valid, rx_length, rx_type, rx_node, m_if.data} !== '0) begin
      miscompares++;
      $display("FAIL mid_fcs_reset_outputs got %b/%h/%h/%h/%h exp all zero", {rx_start, rx_end, rx_ok, rx_error, m_if.first, m_if.last, m_if.valid}, rx_length, rx_type, rx_node, m_if.data);
    end
    vectors++;
    if (state !== IDLE) begin miscompares++; $display("FAIL mid_fcs_state got %0d exp %0d", state, IDLE); end
    reset = 1'b0;
    repeat (4) @(negedge clk);
    vectors++;
    if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL mid_fcs_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL mid_fcs_ev%0d got %h exp %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random(input int frames, input int gmax);
    logic [15:0] len;
    logic [7:0]  typ, node;
    bit          bad;
    clear_all();
    for (int f = 0; f < frames; f++) begin
      len  = 16'($urandom_range(15, 0));
      typ  = 8'($urandom);
      node = 8'($urandom);
      bad  = ($urandom_range(2, 0) == 0);
      add_frame(len, typ, node, 1'b0, bad ? (32'h1 << $urandom_range(31, 0)) : 32'h0);
      expect_good_frame(frame_base, len, typ, node, !bad);
    end
    drive_stream(stim_q.size(), 0, gmax);
    repeat (4) @(negedge clk);
    vectors++;
    if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL random_g%0d_count got %0d exp %0d", gmax, obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL random_g%0d_ev%0d got %h exp %h", gmax, i, obs_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    s_if.valid = 1'b0;
    s_if.first = 1'b0;
    s_if.last  = 1'b0;
    s_if.data  = 8'h00;
    test_reset();
    test_loopback();
    test_fcs_error();
    test_abort();
    test_preamble_error();
    test_first_restart();
    test_gapped();
    test_trail_and_short();
    test_reset_mid_fcs();
    test_random(4, 0);
    test_random(6, 3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
